player_move_capture: RTL and testbench

//  Input-side counterpart of the SSD/VGA output path: reads the player's move from the board inputs.

---
 rtl/player_move_capture.sv | 158 +++++++++++++++
 tb/tb_player_move_capture.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_capture.sv
// Commit-button and switch capture for a player move.
// Build option PMC_ONEHOT_EN selects one-hot coordinate decode.
module player_move_capture #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int GRID_SIZE       = 11
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       btn_in,
    input  logic [7:0] row_sw,
    input  logic [7:0] col_sw,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_row,
    output logic [3:0] move_col,
    output logic       move_reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        OFFER,
        WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef PMC_ONEHOT_EN
    localparam int OH_GRID = (GRID_SIZE > 8) ? 8 : GRID_SIZE;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_m, btn_s;
    logic [7:0]       row_m, row_s;
    logic [7:0]       col_m, col_s;
    logic [4:0]       row_dec, col_dec;
    logic             move_legal;
    logic             latch_en;
    logic             reject_d, reject_q;

    // Returns {legal, coord} for one switch bank.
    function automatic logic [4:0] decode(input logic [7:0] sw);
        logic [3:0] idx;
        logic       ok;
`ifdef PMC_ONEHOT_EN
        idx = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (sw[i]) idx = 4'(i);
        end
        ok = $onehot(sw) && (int'(idx) < OH_GRID);
`else
        idx = sw[3:0];
        ok  = (sw[7:4] == 4'd0) && (int'(sw[3:0]) < GRID_SIZE);
`endif
        return {ok, idx};
    endfunction

    // Two-flop synchronisers on every asynchronous board input.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            row_m <= 8'd0;
            row_s <= 8'd0;
            col_m <= 8'd0;
            col_s <= 8'd0;
        end else begin
            btn_m <= btn_in;
            btn_s <= btn_m;
            row_m <= row_sw;
            row_s <= row_m;
            col_m <= col_sw;
            col_s <= col_m;
        end
    end

    assign row_dec    = decode(row_s);
    assign col_dec    = decode(col_s);
    assign move_legal = row_dec[4] & col_dec[4];

    // State, counter, latched coordinate and reject pulse registers.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            move_row <= 4'd0;
            move_col <= 4'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reject_q <= reject_d;
            if (latch_en) begin
                move_row <= row_dec[3:0];
                move_col <= col_dec[3:0];
            end
        end
    end

    // Next-state and counter logic; counter never passes CNT_LAST.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) state_d = DB_PRESS;
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    latch_en = 1'b1;
                    if (move_legal) begin
                        state_d = OFFER;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = WAIT_REL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OFFER: begin
                if (move_ready) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end
            end
            WAIT_REL: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign move_valid  = (state_q == OFFER);
    assign move_reject = reject_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_player_move_capture.sv
// Directed bench for player_move_capture (DEBOUNCE_CYCLES=4).
// Vectors follow the decode mode chosen by PMC_ONEHOT_EN.
module tb_player_move_capture;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

`ifdef PMC_ONEHOT_EN
    localparam logic [7:0] T1_ROW = 8'h10, T1_COL = 8'h01;
    localparam logic [3:0] T1_ER  = 4'd4,  T1_EC  = 4'd0;
    localparam logic [7:0] RJ1_ROW = 8'h11, RJ1_COL = 8'h01;
    localparam logic [7:0] RJ2_ROW = 8'h01, RJ2_COL = 8'h00;
    localparam logic [7:0] T4_ROW = 8'h20, T4_COL = 8'h80;
    localparam logic [3:0] T4_ER  = 4'd5,  T4_EC  = 4'd7;
    localparam logic [7:0] T5_ROW = 8'h04, T5_COL = 8'h40;
    localparam logic [3:0] T5_ER  = 4'd2,  T5_EC  = 4'd6;
`else
    localparam logic [7:0] T1_ROW = 8'h03, T1_COL = 8'h07;
    localparam logic [3:0] T1_ER  = 4'd3,  T1_EC  = 4'd7;
    localparam logic [7:0] RJ1_ROW = 8'h0B, RJ1_COL = 8'h00;
    localparam logic [7:0] RJ2_ROW = 8'h00, RJ2_COL = 8'h10;
    localparam logic [7:0] T4_ROW = 8'h05, T4_COL = 8'h09;
    localparam logic [3:0] T4_ER  = 4'd5,  T4_EC  = 4'd9;
    localparam logic [7:0] T5_ROW = 8'h02, T5_COL = 8'h0A;
    localparam logic [3:0] T5_ER  = 4'd2,  T5_EC  = 4'd10;
`endif

    logic       board_clk;
    logic       Reset;
    logic       btn_in;
    logic [7:0] row_sw;
    logic [7:0] col_sw;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] move_row;
    logic [3:0] move_col;
    logic       move_reject;
    logic       busy;

    int n_checks;
    int n_fail;

    player_move_capture #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(4),
        .GRID_SIZE(11)
    ) dut (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .btn_in     (btn_in),
        .row_sw     (row_sw),
        .col_sw     (col_sw),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_row   (move_row),
        .move_col   (move_col),
        .move_reject(move_reject),
        .busy       (busy)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic test_reset();
        Reset = 1'b1;
        btn_in = 1'b0;
        row_sw = 8'h00;
        col_sw = 8'h00;
        move_ready = 1'b0;
        repeat (3) @(negedge board_clk);
        n_checks++;
        if ({move_valid, move_reject, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000",
                     {move_valid, move_reject, busy});
        end
        n_checks++;
        if ({move_row, move_col} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_coord got %h want 00",
                     {move_row, move_col});
        end
        Reset = 1'b0;
        repeat (2) @(negedge board_clk);
    endtask

    task automatic test_single_move();
        int lat;
        int pulses;
        int rej;
        int waited;
        row_sw = T1_ROW;
        col_sw = T1_COL;
        move_ready = 1'b1;
        btn_in = 1'b1;
        lat = 0;
        rej = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge board_clk);
            if (move_valid) lat = i;
        end
        n_checks++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL single_latency got %0d want %0d", lat, LAT);
        end
        n_checks++;
        if ({move_row, move_col} !== {T1_ER, T1_EC}) begin
            n_fail++;
            $display("FAIL single_coord got %h want %h",
                     {move_row, move_col}, {T1_ER, T1_EC});
        end
        pulses = (lat != 0) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge board_clk);
            if (move_valid) pulses++;
            if (move_reject) rej++;
        end
        n_checks++;
        if (pulses != 1 || rej != 0) begin
            n_fail++;
            $display("FAIL single_pulses got %0d/%0d want 1/0", pulses, rej);
        end
        btn_in = 1'b0;
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge board_clk);
            waited++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release busy got %b want 0", busy);
        end
        move_ready = 1'b0;
    endtask

    task automatic test_glitch();
        int bad;
        bit saw_busy;
        bad = 0;
        saw_busy = 1'b0;
        row_sw = T1_ROW;
        col_sw = T1_COL;
        btn_in = 1'b1;
        repeat (2) @(negedge board_clk);
        btn_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge board_clk);
            if (move_valid || move_reject) bad++;
            if (busy) saw_busy = 1'b1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL glitch_outputs got %0d active cycles want 0", bad);
        end
        n_checks++;
        if (saw_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_seen got %b want 1", saw_busy);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_reject();
        logic [15:0] vec [2];
        vec[0] = {RJ1_ROW, RJ1_COL};
        vec[1] = {RJ2_ROW, RJ2_COL};
        move_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            int lat;
            int extra;
            int vld;
            int waited;
            row_sw = vec[v][15:8];
            col_sw = vec[v][7:0];
            btn_in = 1'b1;
            lat = 0;
            extra = 0;
            vld = 0;
            for (int i = 1; i <= 20 && lat == 0; i++) begin
                @(negedge board_clk);
                if (move_valid) vld++;
                if (move_reject) lat = i;
            end
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL reject%0d_latency got %0d want %0d",
                         v, lat, LAT);
            end
            for (int i = 0; i < 10; i++) begin
                @(negedge board_clk);
                if (move_reject) extra++;
                if (move_valid) vld++;
            end
            n_checks++;
            if (extra != 0 || vld != 0) begin
                n_fail++;
                $display("FAIL reject%0d_pulse extra=%0d valid=%0d want 0/0",
                         v, extra, vld);
            end
            btn_in = 1'b0;
            waited = 0;
            while (busy && waited < 20) begin
                @(negedge board_clk);
                waited++;
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reject%0d_idle busy got %b want 0", v, busy);
            end
        end
        move_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int found;
        int waited;
        move_ready = 1'b0;
        row_sw = T4_ROW;
        col_sw = T4_COL;
        btn_in = 1'b1;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            @(negedge board_clk);
            if (move_valid) found = i;
        end
        n_checks++;
        if (found != LAT) begin
            n_fail++;
            $display("FAIL bp_offer latency got %0d want %0d", found, LAT);
        end
        for (int i = 0; i < 20; i++) begin
            row_sw = ~row_sw;
            col_sw = col_sw ^ 8'h5A;
            btn_in = ~btn_in;
            @(negedge board_clk);
            n_checks++;
            if ({move_valid, move_row, move_col} !== {1'b1, T4_ER, T4_EC}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got %h want %h", i,
                         {move_valid, move_row, move_col},
                         {1'b1, T4_ER, T4_EC});
            end
        end
        move_ready = 1'b1;
        @(negedge board_clk);
        n_checks++;
        if ({move_valid, move_row, move_col} !== {1'b0, T4_ER, T4_EC}) begin
            n_fail++;
            $display("FAIL bp_accept got %h want %h",
                     {move_valid, move_row, move_col},
                     {1'b0, T4_ER, T4_EC});
        end
        move_ready = 1'b0;
        btn_in = 1'b0;
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge board_clk);
            waited++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int found;
        int waited;
        move_ready = 1'b0;
        row_sw = T1_ROW;
        col_sw = T1_COL;
        btn_in = 1'b1;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            @(negedge board_clk);
            if (move_valid) found = i;
        end
        n_checks++;
        if (found != LAT) begin
            n_fail++;
            $display("FAIL rst_offer latency got %0d want %0d", found, LAT);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({move_valid, move_reject, busy, move_row, move_col} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_async got %h want 000",
                     {move_valid, move_reject, busy, move_row, move_col});
        end
        btn_in = 1'b0;
        @(negedge board_clk);
        Reset = 1'b0;
        row_sw = T5_ROW;
        col_sw = T5_COL;
        move_ready = 1'b1;
        btn_in = 1'b1;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            @(negedge board_clk);
            if (move_valid) found = i;
        end
        n_checks++;
        if (found != LAT) begin
            n_fail++;
            $display("FAIL rst_again latency got %0d want %0d", found, LAT);
        end
        n_checks++;
        if ({move_row, move_col} !== {T5_ER, T5_EC}) begin
            n_fail++;
            $display("FAIL rst_again_coord got %h want %h",
                     {move_row, move_col}, {T5_ER, T5_EC});
        end
        btn_in = 1'b0;
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge board_clk);
            waited++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_again_idle busy got %b want 0", busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_single_move();
        test_glitch();
        test_reject();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
